// File: rtl/izh_state_rmw_ctrl.sv
// Read-modify-write sequencer for the Izhikevich neuron state SRAM: single-neuron
// event updates and full time-reference sweeps over neurons 0..N-1.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RD    | read strobe to addr_q
// LAT   | SRAM read latency, rdata captured into the state register
// UPD   | state word presented to the update logic, next state captured
// WB    | write-back of the next state to addr_q
module izh_state_rmw_ctrl #(
    parameter int N       = 256,
    parameter int M       = 8,
    parameter int STATE_W = 55
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [M-1:0]       req_addr,
    input  logic [1:0]         req_type,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [M-1:0]       sram_addr,
    output logic [STATE_W-1:0] sram_wdata,
    input  logic [STATE_W-1:0] sram_rdata,
    output logic               upd_valid,
    output logic [STATE_W-1:0] upd_state,
    output logic [1:0]         upd_type,
    output logic               upd_tref,
    input  logic [STATE_W-1:0] upd_state_next,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        LAT  = 3'd2,
        UPD  = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [M-1:0] LAST_ADDR = M'(N - 1);

    state_t             state_q, state_d;
    logic [M-1:0]       addr_q;
    logic [1:0]         type_q;
    logic               sweep_q;
    logic [STATE_W-1:0] word_q;
    logic [STATE_W-1:0] wb_q;
    logic               sweep_done_q;
    logic               req_ok;
    logic               accept;
    logic               last_nrn;

    // Reserved type and out-of-range addresses are accepted but never touch the SRAM.
    assign req_ok   = (req_type == 2'b10) ||
                      ((req_type[1] == 1'b0) && (32'(req_addr) < 32'(N)));
    assign accept   = req_valid && (state_q == IDLE);
    assign last_nrn = (addr_q == LAST_ADDR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b1;
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        upd_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid && req_ok) state_d = RD;
            end
            RD: begin
                sram_cs = 1'b1;
                state_d = LAT;
            end
            LAT: state_d = UPD;
            UPD: begin
                upd_valid = 1'b1;
                state_d   = WB;
            end
            WB: begin
                sram_cs = 1'b1;
                sram_we = 1'b1;
                state_d = (sweep_q && !last_nrn) ? RD : IDLE;
            end
            default: begin
                state_d = IDLE;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q       <= '0;
            type_q       <= 2'b00;
            sweep_q      <= 1'b0;
            word_q       <= '0;
            wb_q         <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            if (accept && req_ok) begin
                type_q  <= req_type;
                addr_q  <= (req_type == 2'b10) ? '0 : req_addr;
                sweep_q <= (req_type == 2'b10);
            end
            if (state_q == LAT) word_q <= sram_rdata;
            if (state_q == UPD) wb_q <= upd_state_next;
            // Sweep ends by compare against the last neuron, never by counter wrap.
            if (state_q == WB && sweep_q) begin
                if (!last_nrn) addr_q  <= addr_q + M'(1);
                else           sweep_q <= 1'b0;
            end
            sweep_done_q <= (state_q == WB) && sweep_q && last_nrn;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wb_q;
    assign upd_state  = word_q;
    assign upd_type   = type_q;
    assign upd_tref   = sweep_q;
    assign sweep_done = sweep_done_q;

endmodule
